cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) / ROB writeback path among NUM_REQ functional units (ALU, multiplier, load unit, ...).
- Each FU pushes a registered writeback payload through a valid/ready handshake into a private FIFO.
- The arbiter grants one FIFO head per cycle round-robin and drives a registered CDB/ROB broadcast.
- Sits between the execute-stage FU output registers and the ROB/register-file/reservation-station snoop ports.

---
 rtl/cdb_arbiter_if.sv | 41 ++++
 rtl/cdb_arbiter.sv | 154 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus bundle: FU writeback handshakes in, CDB broadcast out.
// slave = arbiter side, master = FU / ROB side.
interface cdb_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int PAYLOAD_WIDTH = 16,
  parameter int FIFO_DEPTH    = 2
);
  localparam int SW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                             flush_i;
  logic [NUM_REQ-1:0]               req_v_i;
  logic [NUM_REQ*PAYLOAD_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]               req_ready_o;
  logic                             wb_v_o;
  logic [PAYLOAD_WIDTH-1:0]         wb_data_o;
  logic [SW-1:0]                    wb_src_o;
  logic [NUM_REQ*CW-1:0]            occupancy_o;

  modport slave (
    input  flush_i,
    input  req_v_i,
    input  req_data_i,
    output req_ready_o,
    output wb_v_o,
    output wb_data_o,
    output wb_src_o,
    output occupancy_o
  );

  modport master (
    output flush_i,
    output req_v_i,
    output req_data_i,
    input  req_ready_o,
    input  wb_v_o,
    input  wb_data_o,
    input  wb_src_o,
    input  occupancy_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB writeback arbiter: per-FU FIFOs, one registered broadcast per cycle.
// Define CDB_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module cdb_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int PAYLOAD_WIDTH = 16,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  cdb_arbiter_if.slave bus
);
  localparam int SW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef logic [PAYLOAD_WIDTH-1:0] pl_t;

  pl_t              mem_q [NUM_REQ][FIFO_DEPTH];
  logic [AW-1:0]    rd_q  [NUM_REQ];
  logic [AW-1:0]    wr_q  [NUM_REQ];
  logic [CW-1:0]    cnt_q [NUM_REQ];
  logic [CW-1:0]    cnt_d [NUM_REQ];
  pl_t              head  [NUM_REQ];

  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] nempty;
  logic [NUM_REQ*CW-1:0] occ;

  logic          any;
  logic [SW-1:0] win;
  logic          grant;

  logic                     wb_v_q;
  logic [PAYLOAD_WIDTH-1:0] wb_data_q;
  logic [SW-1:0]            wb_src_q;

  // Ready comes from the registered count only: no pop->ready path.
  always_comb begin
    ready  = '0;
    push   = '0;
    nempty = '0;
    occ    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      ready[k]  = ~reset_i & (cnt_q[k] != CW'(FIFO_DEPTH));
      push[k]   = bus.req_v_i[k] & ready[k];
      nempty[k] = (cnt_q[k] != '0);
      head[k]   = mem_q[k][rd_q[k]];
      occ[k*CW +: CW] = cnt_q[k];
    end
  end

`ifdef CDB_ARB_FIXED_PRIO_EN
  always_comb begin
    any = 1'b0;
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (nempty[i]) begin
        any = 1'b1;
        win = SW'(i);
      end
    end
  end
`else
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_d;

  // Scan backwards so the last hit is the first after ptr.
  always_comb begin
    int idx;
    any = 1'b0;
    win = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (nempty[SW'(idx)]) begin
        any = 1'b1;
        win = SW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = win;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ptr_q <= SW'(NUM_REQ - 1);
    else         ptr_q <= ptr_d;
  end
`endif

  assign grant = any & ~bus.flush_i;

  always_comb begin
    pop = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pop[k]   = any & (win == SW'(k));
      cnt_d[k] = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cnt_q[k] <= '0;
        rd_q[k]  <= '0;
        wr_q[k]  <= '0;
      end
    end else if (bus.flush_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cnt_q[k] <= '0;
        rd_q[k]  <= '0;
        wr_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cnt_q[k] <= cnt_d[k];
        if (push[k]) wr_q[k] <= wr_q[k] + AW'(1);
        if (pop[k])  rd_q[k] <= rd_q[k] + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (push[k] && !bus.flush_i)
        mem_q[k][wr_q[k]] <=
          bus.req_data_i[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wb_v_q    <= 1'b0;
      wb_data_q <= '0;
      wb_src_q  <= '0;
    end else begin
      wb_v_q <= grant;
      if (grant) begin
        wb_data_q <= head[win];
        wb_src_q  <= win;
      end
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.wb_v_o      = wb_v_q;
  assign bus.wb_data_o   = wb_data_q;
  assign bus.wb_src_o    = wb_src_q;
  assign bus.occupancy_o = occ;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, RR order, full FIFO, flush.
// Fixed-priority scenario runs when CDB_ARB_FIXED_PRIO_EN is defined.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int PW = 16;
  localparam int D  = 2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [PW-1:0] qs [N][$];
  logic          exp_v    [16];
  logic [1:0]    exp_src  [16];
  logic [PW-1:0] exp_data [16];
  logic [3:0]    exp_rdy  [16];

  cdb_arbiter_if #(.NUM_REQ(N), .PAYLOAD_WIDTH(PW), .FIFO_DEPTH(D)) bus ();

  cdb_arbiter #(.NUM_REQ(N), .PAYLOAD_WIDTH(PW), .FIFO_DEPTH(D)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input int c, input logic v, input logic [1:0] s,
                    input logic [PW-1:0] d, input logic [3:0] r);
    exp_v[c]    = v;
    exp_src[c]  = s;
    exp_data[c] = d;
    exp_rdy[c]  = r;
  endtask

  // Each requester presents its queue head and holds it until accepted.
  task automatic run(input int n, input string tag);
    logic [N-1:0] acc;
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < N; k++) begin
        bus.req_v_i[k] = (qs[k].size() != 0);
        bus.req_data_i[k*PW +: PW] = bus.req_v_i[k] ? qs[k][0] : '0;
      end
      acc = bus.req_v_i & bus.req_ready_o;
      tick();
      for (int k = 0; k < N; k++)
        if (acc[k]) void'(qs[k].pop_front());
      chk($sformatf("%s[%0d].wb_v", tag, c), 64'(bus.wb_v_o), 64'(exp_v[c]));
      if (exp_v[c]) begin
        chk($sformatf("%s[%0d].src", tag, c),
            64'(bus.wb_src_o), 64'(exp_src[c]));
        chk($sformatf("%s[%0d].data", tag, c),
            64'(bus.wb_data_o), 64'(exp_data[c]));
      end
      chk($sformatf("%s[%0d].rdy", tag, c),
          64'(bus.req_ready_o), 64'(exp_rdy[c]));
    end
    bus.req_v_i    = '0;
    bus.req_data_i = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.flush_i    = 1'b0;
    bus.req_v_i    = '0;
    bus.req_data_i = '0;
    #1;
    chk("rst.rdy", 64'(bus.req_ready_o), 64'h0);
    chk("rst.wb_v", 64'(bus.wb_v_o), 64'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("rel.rdy", 64'(bus.req_ready_o), 64'hF);
    chk("rel.occ", 64'(bus.occupancy_o), 64'h0);
    chk("rel.data", 64'(bus.wb_data_o), 64'h0);
    chk("rel.src", 64'(bus.wb_src_o), 64'h0);

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) qs[k].push_back(PW'(16'h100 * (r + 1) + k));
      ex(0, 0, 0, 0, 4'hF);
      for (int k = 0; k < N; k++)
        ex(k + 1, 1, 2'(k), PW'(16'h100 * (r + 1) + k), 4'hF);
      ex(5, 0, 0, 0, 4'hF);
      run(6, $sformatf("rr%0d", r));
    end

    qs[2].push_back(16'h01A5);
    ex(0, 0, 0, 0, 4'hF);
    ex(1, 1, 2, 16'h01A5, 4'hF);
    ex(2, 0, 0, 0, 4'hF);
    run(3, "single");
    chk("hold.data", 64'(bus.wb_data_o), 64'h1A5);
    chk("hold.src", 64'(bus.wb_src_o), 64'h2);

`ifdef CDB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) qs[0].push_back(PW'(16'h0A0 + i));
    for (int i = 0; i < 3; i++) qs[3].push_back(PW'(16'h0D0 + i));
    ex(0, 0, 0, 0,        4'hF);
    ex(1, 1, 0, 16'h0A0,  4'h7);
    ex(2, 1, 0, 16'h0A1,  4'h7);
    ex(3, 1, 0, 16'h0A2,  4'h7);
    ex(4, 1, 3, 16'h0D0,  4'hF);
    ex(5, 1, 3, 16'h0D1,  4'hF);
    ex(6, 1, 3, 16'h0D2,  4'hF);
    ex(7, 0, 0, 0,        4'hF);
    run(8, "prio");
    chk("prio.left3", 64'(qs[3].size()), 64'h0);
`else
    for (int i = 0; i < 4; i++) qs[0].push_back(PW'(16'h0A0 + i));
    for (int i = 0; i < 3; i++) qs[1].push_back(PW'(16'h0B0 + i));
    ex(0, 0, 0, 0,        4'hF);
    ex(1, 1, 0, 16'h0A0,  4'hD);
    ex(2, 1, 1, 16'h0B0,  4'hE);
    ex(3, 1, 0, 16'h0A1,  4'hD);
    ex(4, 1, 1, 16'h0B1,  4'hE);
    ex(5, 1, 0, 16'h0A2,  4'hF);
    ex(6, 1, 1, 16'h0B2,  4'hF);
    ex(7, 1, 0, 16'h0A3,  4'hF);
    ex(8, 0, 0, 0,        4'hF);
    run(9, "full");
    chk("full.left0", 64'(qs[0].size()), 64'h0);
    chk("full.left1", 64'(qs[1].size()), 64'h0);
`endif

    bus.req_v_i = 4'hF;
    for (int k = 0; k < N; k++) bus.req_data_i[k*PW +: PW] = PW'(16'h500 + k);
    tick();
    chk("fl.occ1", 64'(bus.occupancy_o), 64'h55);
    chk("fl.wb1", 64'(bus.wb_v_o), 64'h0);
    bus.req_v_i = 4'b1100;
    bus.req_data_i[2*PW +: PW] = 16'h05F2;
    bus.req_data_i[3*PW +: PW] = 16'h05F3;
    tick();
    chk("fl.wb2", 64'(bus.wb_v_o), 64'h1);
`ifdef CDB_ARB_FIXED_PRIO_EN
    chk("fl.occ2", 64'(bus.occupancy_o), 64'hA4);
`else
    chk("fl.occ2", 64'(bus.occupancy_o), 64'hA1);
`endif
    bus.flush_i = 1'b1;
    bus.req_v_i = 4'b0001;
    bus.req_data_i[0 +: PW] = 16'h05EE;
    chk("fl.rdy_pre", 64'(bus.req_ready_o), 64'h3);
    tick();
    bus.flush_i = 1'b0;
    bus.req_v_i = '0;
    chk("fl.wb3", 64'(bus.wb_v_o), 64'h0);
    chk("fl.occ3", 64'(bus.occupancy_o), 64'h0);
    chk("fl.rdy3", 64'(bus.req_ready_o), 64'hF);
    tick();
    chk("fl.wb4", 64'(bus.wb_v_o), 64'h0);
    bus.req_v_i = 4'b1000;
    bus.req_data_i[3*PW +: PW] = 16'h03C3;
    tick();
    bus.req_v_i = '0;
    chk("post.wb0", 64'(bus.wb_v_o), 64'h0);
    chk("post.occ", 64'(bus.occupancy_o), 64'h40);
    tick();
    chk("post.wb1", 64'(bus.wb_v_o), 64'h1);
    chk("post.src", 64'(bus.wb_src_o), 64'h3);
    chk("post.data", 64'(bus.wb_data_o), 64'h3C3);

    bus.req_v_i = 4'b0111;
    for (int k = 0; k < N; k++) bus.req_data_i[k*PW +: PW] = PW'(16'h600 + k);
    tick();
    tick();
    bus.req_v_i = '0;
    chk("mr.wb_pre", 64'(bus.wb_v_o), 64'h1);
    #3;
    reset = 1'b1;
    #1;
    chk("mr.wb_v", 64'(bus.wb_v_o), 64'h0);
    chk("mr.data", 64'(bus.wb_data_o), 64'h0);
    chk("mr.rdy", 64'(bus.req_ready_o), 64'h0);
    chk("mr.occ", 64'(bus.occupancy_o), 64'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("mr.rdy_rel", 64'(bus.req_ready_o), 64'hF);
    bus.req_v_i = 4'b0110;
    for (int k = 0; k < N; k++) bus.req_data_i[k*PW +: PW] = PW'(16'h700 + k);
    tick();
    bus.req_v_i = '0;
    chk("mr.wb_e", 64'(bus.wb_v_o), 64'h0);
    tick();
    chk("mr.src1", 64'(bus.wb_src_o), 64'h1);
    chk("mr.data1", 64'(bus.wb_data_o), 64'h701);
    tick();
    chk("mr.src2", 64'(bus.wb_src_o), 64'h2);
    chk("mr.data2", 64'(bus.wb_data_o), 64'h702);
    tick();
    chk("mr.idle", 64'(bus.wb_v_o), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
